// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS sequencer sharing one memory port between fetch and data.
// Optional ILLEGAL_TRAP_EN makes illegal opcodes a sticky trap instead of a retiring NOP.
module mips_multicycle_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [5:0]           i_op,
    input  logic [5:0]           i_funct,
    input  logic                 i_zero,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_iord,
    output logic                 o_memwrite,
    output logic                 o_irwrite,
    output logic                 o_pcwrite,
    output logic                 o_branch,
    output logic                 o_pcen,
    output logic [1:0]           o_pcsrc,
    output logic                 o_alusrca,
    output logic [1:0]           o_alusrcb,
    output logic [3:0]           o_alucontrol,
    output logic                 o_signext,
    output logic                 o_shiftl16,
    output logic                 o_regdst,
    output logic                 o_memtoreg,
    output logic                 o_regwrite,
    output logic                 o_lb_en,
    output logic [CNT_WIDTH-1:0] o_instret,
    output logic                 o_trap
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_ILLEGAL
    } state_t;
    localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b1010, ALU_AND = 4'b0000,
                           ALU_OR = 4'b0001, ALU_SLT = 4'b1011, ALU_XOR = 4'b0100;
    state_t                r_state, w_next;
    logic [CNT_WIDTH-1:0]  r_instret;
    logic                  w_mem_req, w_iord, w_memwrite, w_irwrite, w_pcwrite, w_branch;
    logic                  w_alusrca, w_signext, w_shiftl16, w_regdst, w_memtoreg, w_regwrite, w_lb_en;
    logic [1:0]            w_pcsrc, w_alusrcb;
    logic [3:0]            w_alucontrol, w_r_alu;
    logic                  w_funct_ok, w_retire;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end
    // funct stays valid from DECODE on, so ALUWB can re-derive whether the R-type was legal
    always_comb begin
        w_r_alu    = ALU_ADD;
        w_funct_ok = 1'b1;
        case (i_funct)
            6'b100000, 6'b100001: w_r_alu = ALU_ADD;
            6'b100010, 6'b100011: w_r_alu = ALU_SUB;
            6'b100100:            w_r_alu = ALU_AND;
            6'b100101:            w_r_alu = ALU_OR;
            6'b101010:            w_r_alu = ALU_SLT;
            6'b100110:            w_r_alu = ALU_XOR;
            default:              w_funct_ok = 1'b0;
        endcase
    end
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_pcsrc      = 2'b00;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_alucontrol = 4'b0000;
        w_signext    = 1'b0;
        w_shiftl16   = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_lb_en      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_irwrite    = i_mem_ready;
                w_pcwrite    = i_mem_ready;
                w_alusrcb    = i_mem_ready ? 2'b01 : 2'b00;
                w_alucontrol = i_mem_ready ? ALU_ADD : 4'b0000;
                w_next       = i_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrcb    = 2'b11;
                w_signext    = 1'b1;
                w_alucontrol = ALU_ADD;
                case (i_op)
                    6'b000000:                       w_next = S_EXEC;
                    6'b100011, 6'b101011, 6'b100100: w_next = S_MEMADR;
                    6'b000100:                       w_next = S_BRANCH;
                    6'b001000, 6'b001001, 6'b001101,
                    6'b001110, 6'b001111:            w_next = S_IEXEC;
                    6'b000010:                       w_next = S_JUMP;
                    default:                         w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_signext    = 1'b1;
                w_alucontrol = ALU_ADD;
                w_next       = (i_op == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_next    = i_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_lb_en    = (i_op == 6'b100100);
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req  = 1'b1;
                w_iord     = 1'b1;
                w_memwrite = i_mem_ready;
                w_next     = i_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                w_alusrca    = 1'b1;
                w_alucontrol = w_r_alu;
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = w_funct_ok;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ALU_SUB;
                w_branch     = 1'b1;
                w_pcsrc      = 2'b01;
                w_next       = S_FETCH;
            end
            S_IEXEC: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_signext    = (i_op == 6'b001000) || (i_op == 6'b001001);
                w_shiftl16   = (i_op == 6'b001111);
                w_alucontrol = (i_op == 6'b001101) ? ALU_OR : (i_op == 6'b001110) ? ALU_XOR : ALU_ADD;
                w_next       = S_IWB;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL: w_next = S_ILLEGAL;
`else
            S_ILLEGAL: w_next = S_FETCH;
`endif
            default: w_next = S_FETCH;
        endcase
    end
    assign w_retire     = (r_state != S_FETCH) && (w_next == S_FETCH);
    assign o_mem_req    = i_reset & w_mem_req;
    assign o_iord       = i_reset & w_iord;
    assign o_memwrite   = i_reset & w_memwrite;
    assign o_irwrite    = i_reset & w_irwrite;
    assign o_pcwrite    = i_reset & w_pcwrite;
    assign o_branch     = i_reset & w_branch;
    assign o_pcen       = i_reset & (w_pcwrite | (w_branch & i_zero));
    assign o_pcsrc      = i_reset ? w_pcsrc : 2'b00;
    assign o_alusrca    = i_reset & w_alusrca;
    assign o_alusrcb    = i_reset ? w_alusrcb : 2'b00;
    assign o_alucontrol = i_reset ? w_alucontrol : 4'b0000;
    assign o_signext    = i_reset & w_signext;
    assign o_shiftl16   = i_reset & w_shiftl16;
    assign o_regdst     = i_reset & w_regdst;
    assign o_memtoreg   = i_reset & w_memtoreg;
    assign o_regwrite   = i_reset & w_regwrite;
    assign o_lb_en      = i_reset & w_lb_en;
    assign o_instret    = i_reset ? r_instret : '0;
`ifdef ILLEGAL_TRAP_EN
    assign o_trap       = i_reset & (r_state == S_ILLEGAL);
`else
    assign o_trap       = 1'b0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed sequence with a scoreboard of expected control vectors per cycle.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0]  op = 6'd0, funct = 6'd0;
    logic        mem_req, iord, memwrite, irwrite, pcwrite, branch, pcen, alusrca;
    logic        signext, shiftl16, regdst, memtoreg, regwrite, lb_en, trap;
    logic [1:0]  pcsrc, alusrcb;
    logic [3:0]  alucontrol;
    logic [31:0] instret;
    logic [22:0] q_e[$];
    logic [31:0] q_i[$];
    int          n_cmp = 0, n_bad = 0;
    logic [22:0] ZERO, F_WAIT, F_GO, DEC, MADR, MRD, MWB_LBU, MWR_W, MWR_GO, EX_XOR, EX_BAD;
    logic [22:0] AWB, AWB_NOP, BR1, BR0, IEX_LUI, IWB, JMP, ILL;

    mips_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
        .i_clk(clk), .i_reset(reset), .i_op(op), .i_funct(funct), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_iord(iord), .o_memwrite(memwrite),
        .o_irwrite(irwrite), .o_pcwrite(pcwrite), .o_branch(branch), .o_pcen(pcen),
        .o_pcsrc(pcsrc), .o_alusrca(alusrca), .o_alusrcb(alusrcb), .o_alucontrol(alucontrol),
        .o_signext(signext), .o_shiftl16(shiftl16), .o_regdst(regdst), .o_memtoreg(memtoreg),
        .o_regwrite(regwrite), .o_lb_en(lb_en), .o_instret(instret), .o_trap(trap)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] mk(input logic mreq, io, mw, irw, pcw, br, pce,
                                       input logic [1:0] psrc, input logic asa,
                                       input logic [1:0] asb, input logic [3:0] ac,
                                       input logic se, sl, rd, m2r, rw, lb, tr);
        return {mreq, io, mw, irw, pcw, br, pce, psrc, asa, asb, ac, se, sl, rd, m2r, rw, lb, tr};
    endfunction

    task automatic chk(input logic [22:0] e, input logic [31:0] ei, input string tag);
        logic [22:0] obs, pe;
        logic [31:0] pi;
        q_e.push_back(e);
        q_i.push_back(ei);
        #1;
        obs = {mem_req, iord, memwrite, irwrite, pcwrite, branch, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, signext, shiftl16, regdst, memtoreg, regwrite, lb_en, trap};
        pe = q_e.pop_front();
        pi = q_i.pop_front();
        n_cmp++;
        assert (obs === pe) else begin
            n_bad++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, pe);
        end
        n_cmp++;
        assert (instret === pi) else begin
            n_bad++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, pi);
        end
    endtask

    task automatic step(input logic [22:0] e, input logic [31:0] ei, input string tag);
        chk(e, ei, tag);
        @(negedge clk);
    endtask

    initial begin
        ZERO    = '0;
        F_WAIT  = mk(1,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0,0);
        F_GO    = mk(1,0,0,1,1,0,1,2'b00,0,2'b01,4'b0010,0,0,0,0,0,0,0);
        DEC     = mk(0,0,0,0,0,0,0,2'b00,0,2'b11,4'b0010,1,0,0,0,0,0,0);
        MADR    = mk(0,0,0,0,0,0,0,2'b00,1,2'b10,4'b0010,1,0,0,0,0,0,0);
        MRD     = mk(1,1,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0,0);
        MWB_LBU = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,1,1,1,0);
        MWR_W   = mk(1,1,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0,0);
        MWR_GO  = mk(1,1,1,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0,0);
        EX_XOR  = mk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0100,0,0,0,0,0,0,0);
        EX_BAD  = mk(0,0,0,0,0,0,0,2'b00,1,2'b00,4'b0010,0,0,0,0,0,0,0);
        AWB     = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,1,0,1,0,0);
        AWB_NOP = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,1,0,0,0,0);
        BR1     = mk(0,0,0,0,0,1,1,2'b01,1,2'b00,4'b1010,0,0,0,0,0,0,0);
        BR0     = mk(0,0,0,0,0,1,0,2'b01,1,2'b00,4'b1010,0,0,0,0,0,0,0);
        IEX_LUI = mk(0,0,0,0,0,0,0,2'b00,1,2'b10,4'b0010,0,1,0,0,0,0,0);
        IWB     = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,1,0,0);
        JMP     = mk(0,0,0,0,1,0,1,2'b10,0,2'b00,4'b0000,0,0,0,0,0,0,0);
`ifdef ILLEGAL_TRAP_EN
        ILL     = mk(0,0,0,0,0,0,0,2'b00,0,2'b00,4'b0000,0,0,0,0,0,0,1);
`else
        ILL     = ZERO;
`endif
        #2 reset = 1'b0;
        @(negedge clk);
        step(ZERO, 0, "rst_a");
        step(ZERO, 0, "rst_b");
        reset = 1'b1;
        // LW interrupted by reset while in MEMRD with the memory ready
        step(F_WAIT, 0, "lw_fetch_wait");
        mem_ready = 1'b1; op = 6'b100011;
        step(F_GO, 0, "lw_fetch");
        step(DEC, 0, "lw_decode");
        step(MADR, 0, "lw_memadr");
        chk(MRD, 0, "lw_memrd");
        reset = 1'b0;
        chk(ZERO, 0, "rst_in_memrd");
        @(negedge clk);
        step(ZERO, 0, "rst_hold");
        reset = 1'b1; mem_ready = 1'b0;
        // XOR with two fetch wait cycles
        op = 6'b000000; funct = 6'b100110;
        step(F_WAIT, 0, "xor_wait1");
        step(F_WAIT, 0, "xor_wait2");
        mem_ready = 1'b1;
        step(F_GO, 0, "xor_fetch");
        step(DEC, 0, "xor_decode");
        step(EX_XOR, 0, "xor_exec");
        step(AWB, 0, "xor_aluwb");
        // LBU
        op = 6'b100100;
        step(F_GO, 1, "lbu_fetch");
        step(DEC, 1, "lbu_decode");
        step(MADR, 1, "lbu_memadr");
        step(MRD, 1, "lbu_memrd");
        step(MWB_LBU, 1, "lbu_memwb");
        // BEQ taken then not taken
        op = 6'b000100;
        step(F_GO, 2, "beq1_fetch");
        step(DEC, 2, "beq1_decode");
        zero = 1'b1;
        step(BR1, 2, "beq1_branch");
        zero = 1'b0;
        step(F_GO, 3, "beq0_fetch");
        step(DEC, 3, "beq0_decode");
        step(BR0, 3, "beq0_branch");
        // LUI
        op = 6'b001111;
        step(F_GO, 4, "lui_fetch");
        step(DEC, 4, "lui_decode");
        step(IEX_LUI, 4, "lui_iexec");
        step(IWB, 4, "lui_iwb");
        // SW with one data wait cycle
        op = 6'b101011;
        step(F_GO, 5, "sw_fetch");
        step(DEC, 5, "sw_decode");
        step(MADR, 5, "sw_memadr");
        mem_ready = 1'b0;
        step(MWR_W, 5, "sw_memwr_wait");
        mem_ready = 1'b1;
        step(MWR_GO, 5, "sw_memwr");
        // R-type with unknown funct retires as a NOP
        op = 6'b000000; funct = 6'b111111;
        step(F_GO, 6, "nop_fetch");
        step(DEC, 6, "nop_decode");
        step(EX_BAD, 6, "nop_exec");
        step(AWB_NOP, 6, "nop_aluwb");
        // J
        op = 6'b000010;
        step(F_GO, 7, "j_fetch");
        step(DEC, 7, "j_decode");
        step(JMP, 7, "j_jump");
        // illegal opcode
        op = 6'b111111;
        step(F_GO, 8, "ill_fetch");
        step(DEC, 8, "ill_decode");
        step(ILL, 8, "ill_state");
`ifdef ILLEGAL_TRAP_EN
        step(ILL, 8, "ill_stuck1");
        step(ILL, 8, "ill_stuck2");
`else
        step(F_GO, 9, "ill_refetch");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle sequencing FSM for the MIPS core.
- Replaces single-cycle decode so that one unified memory port serves instruction fetch and data access.
- Drives the datapath enables and mux selects each cycle, waits on a memory ready handshake, and counts retired instructions.
- Sits between the instruction register (op/funct), ALU zero flag, and the unified memory.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instret.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
op  in  6  opcode from instruction register (stable from DECODE onward)
funct  in  6  funct field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
iord  out  1  0 = address from PC, 1 = address from ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  load instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  branch-cycle indicator
pcen  out  1  PC register enable = pcwrite | (branch & zero)
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alusrca  out  1  0 = PC, 1 = rs
alusrcb  out  2  00 rt, 01 const 4, 10 extended imm, 11 imm<<2
alucontrol  out  4  0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt, 0100 xor
signext  out  1  sign-extend imm (else zero-extend)
shiftl16  out  1  imm<<16 (LUI)
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  writeback from memory data
regwrite  out  1  register file write
lb_en  out  1  byte-select and zero-extend memory data (LBU)
instret  out  CNT_WIDTH  retired-instruction count
trap  out  1  illegal opcode trap (feature only)

Behaviour:
- Reset low: state <= FETCH, instret <= 0, trap <= 0.
  - While reset is low, all outputs are forced 0 combinationally.
  - Reset mid-instruction abandons it; no partial writes occur after assertion.
- Outputs are Moore on state, except:
  - FETCH and MEMWR strobes are gated by mem_ready.
  - pcen uses zero.
- Every output is 0 unless listed for the state.
- FETCH: mem_req=1, iord=0.
  - If mem_ready: irwrite=1, pcwrite=1, alusrcb=01, alucontrol=add, pcsrc=00; next state DECODE.
  - Else hold with no writes.
- DECODE: alusrcb=11, signext=1, alucontrol=add (branch target into ALUOut). Next state by op:
  - 000000 -> EXEC
  - 100011 LW, 101011 SW, 100100 LBU -> MEMADR
  - 000100 -> BRANCH
  - 001000, 001001, 001101, 001110, 001111 -> IEXEC
  - 000010 -> JUMP
  - anything else -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, signext=1, add. -> MEMRD if op is LW/LBU, MEMWR if SW.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: memtoreg=1, regwrite=1, regdst=0, lb_en=(op==100100). -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. -> FETCH on mem_ready.
- EXEC: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 101010 slt, 100110 xor.
  - Other funct: alucontrol=0010; ALUWB is suppressed (regwrite=0), and it retires as a NOP.
  - -> ALUWB.
- ALUWB: regdst=1, regwrite=1. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01; pcen=zero. -> FETCH.
- IEXEC: alusrca=1, alusrcb=10.
  - ADDI/ADDIU: add, signext=1.
  - ORI: or.
  - XORI: xor.
  - LUI: add, shiftl16=1 (rs=$0).
  - -> IWB.
- IWB: regdst=0, regwrite=1. -> FETCH.
- JUMP: pcsrc=10, pcwrite=1. -> FETCH.
- ILLEGAL: behaviour per feature macro.
- Latency: R/ALU-immediate 4 cycles, LW/LBU 5, SW 4, BEQ 3, J 3, each plus memory wait cycles.
- instret: increments by 1 on the final cycle of each instruction (transition into FETCH). Wraps modulo 2^CNT_WIDTH.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: ILLEGAL asserts trap=1 and holds there (sticky, all strobes 0, instret frozen) until reset.
- Undefined: ILLEGAL is a 1-cycle NOP that retires (instret+1) and -> FETCH. trap is tied 0.

Test Plan:
- Reset low mid-MEMRD with mem_ready=1 -> all strobes 0, instret=0. After release, first cycle is FETCH with mem_req=1, iord=0.
- Fetch op=000000 funct=100110, mem_ready held 0 for 2 cycles -> irwrite/pcwrite stay 0 for those 2 cycles. Then EXEC alucontrol=0100, ALUWB regdst=1 regwrite=1, instret 0->1.
- LBU (op=100100), mem_ready=1 always -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles. MEMWB has lb_en=1, memtoreg=1.
- BEQ with zero=1 -> BRANCH pcen=1, pcsrc=01. Repeat with zero=0 -> pcen=0.
- LUI (001111) -> IEXEC shiftl16=1 alucontrol=0010; IWB regwrite=1 regdst=0. SW -> MEMWR memwrite=1 only on the mem_ready cycle.
- op=111111 -> with ILLEGAL_TRAP_EN, trap=1 and FSM stuck, instret unchanged; without it, returns to FETCH and instret+1.
